// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Purpose : Definitions shared by the UART transmit and receive paths:
//           FSM state encoding, frame constants and the baud divider
//           helper function.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame format: 8 data bits, 1 stop bit, no parity.
    localparam int c_data_bits = 8;
    localparam int c_stop_bits = 1;

    // Transmit FSM state encoding.
    localparam int              c_state_w = 2;
    localparam logic [1:0]      c_st_idle  = 2'd0;
    localparam logic [1:0]      c_st_start = 2'd1;
    localparam logic [1:0]      c_st_data  = 2'd2;
    localparam logic [1:0]      c_st_stop  = 2'd3;

    // Clock cycles per serial bit, truncated.
    function automatic int baud_div(input int oscrate, input int baudrate);
        return oscrate / baudrate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Purpose : Synchronous FIFO holding bytes waiting for the transmitter.
//           A push into a full FIFO and a pop from an empty FIFO are
//           ignored. Push and pop in the same cycle leave the count as is.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           i_push         - write i_push_data this cycle
//           i_pop          - discard the head entry this cycle
//           o_head         - current head entry (valid when o_count != 0)
//           o_count        - occupancy, 0..DEPTH
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = DEPTH[c_aw:0];

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & (r_count != c_full);
    assign w_pop   = i_pop  & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers are exactly c_aw bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Purpose : 8N1 UART transmitter, LSB first. Bytes enter a small FIFO over
//           a valid/ready handshake and are shifted out on tx, back to back
//           while the FIFO holds data.
// Ports   : clk, rst       - clock (OSCRATE Hz), synchronous active-high reset
//           tx_data        - byte to send
//           tx_valid       - tx_data valid this cycle
//           tx_ready       - FIFO can accept a byte
//           tx             - registered serial output, idle high
//           busy           - frame in progress or FIFO non-empty
//           fifo_count     - FIFO occupancy
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int OSCRATE    = 12_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV   = baud_div(OSCRATE, BAUDRATE);
    localparam int c_cnt_w    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int c_cnt_last_i = BAUD_DIV - 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_last_i[c_cnt_w-1:0];
    localparam int c_idx_w    = $clog2(c_data_bits);
    localparam int c_idx_last_i = c_data_bits - 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_last_i[c_idx_w-1:0];
    localparam int c_fc_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_fc_w-1:0] c_full = FIFO_DEPTH[c_fc_w-1:0];

    generate
        if (BAUD_DIV < 2) begin : g_baud_div_check
            $error("uart_tx: OSCRATE/BAUDRATE must be at least 2");
        end
    endgenerate

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [c_cnt_w-1:0]   w_baud_cnt_nxt;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [c_idx_w-1:0]   w_bit_idx_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_bit_done;
    logic                 w_fifo_empty;
    logic [7:0]           w_head;
    logic [c_fc_w-1:0]    w_fifo_count;

    // Ready follows the registered count only, so a full FIFO refuses a
    // push even in a cycle where the FSM pops.
    assign tx_ready     = ~rst & (w_fifo_count != c_full);
    assign w_push       = tx_valid & tx_ready;
    assign w_fifo_empty = (w_fifo_count == '0);
    assign w_bit_done   = (r_baud_cnt == c_cnt_last);
    assign tx           = r_tx;
    assign busy         = (r_state != c_st_idle) | ~w_fifo_empty;
    assign fifo_count   = w_fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (tx_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // The baud counter is zeroed whenever a bit starts, so each bit lasts
    // exactly BAUD_DIV cycles measured from the frame's own start.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt + 1'b1;
        w_bit_idx_nxt  = r_bit_idx;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_tx_nxt       = 1'b1;
                w_baud_cnt_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                if (w_bit_done) begin
                    w_baud_cnt_nxt = '0;
                    w_tx_nxt       = r_shift[0];
                    w_bit_idx_nxt  = '0;
                    w_state_nxt    = c_st_data;
                end
            end
            c_st_data: begin
                if (w_bit_done) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == c_idx_last) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = c_st_stop;
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            c_st_stop: begin
                if (w_bit_done) begin
                    w_baud_cnt_nxt = '0;
                    if (!w_fifo_empty) begin
                        // Back-to-back: next start bit follows the stop bit
                        // with no idle cycle in between.
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = c_st_start;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_tx_nxt       = 1'b1;
                w_baud_cnt_nxt = '0;
                w_state_nxt    = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire
